jk_bank_arbiter: RTL and testbench
==================================

JK_BANK_ARBITER -- requirements
Module: jk_bank_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, giving the width of the JK register bank.
REQ-003 CP  input  1  clock; all state SHALL update on the rising edge of CP only.
REQ-004 RST  input  1  reset; synchronous and active-high.
REQ-005 REQ  input  N_REQ  per-requester request, level; one bit per requester.
REQ-006 OP  input  2*N_REQ  per-requester {J,K} command; requester i uses OP[2i+1:2i].
- 00 = hold; 01 = clear; 10 = set; 11 = toggle.
REQ-007 MASK  input  WIDTH*N_REQ  per-requester bit-select; requester i uses MASK[WIDTH*i +: WIDTH].
REQ-008 GNT  output  N_REQ  one-hot grant; registered.
REQ-009 Q  output  WIDTH  JK register bank state; registered.
REQ-010 QN  output  WIDTH  bitwise complement of Q; combinational.
REQ-011 BUSY  output  1  high while a granted operation is in flight.

Function
REQ-012 The block SHALL contain a two-state FSM with states IDLE and GRANT.
REQ-013 Arbitration SHALL be evaluated in IDLE when any REQ bit is 1.
- Winner: first requester with REQ=1, searching upward from round-robin pointer PTR with wrap-around modulo N_REQ.
REQ-014 At the edge ending an IDLE cycle with a winner w, the block SHALL make the following updates together:
- GNT[w] set to 1;
- OP and MASK of w latched into internal registers;
- state moved to GRANT.
REQ-015 In GRANT, GNT SHALL stay one-hot and constant for exactly one cycle, and BUSY SHALL be 1.
REQ-016 At the edge ending GRANT, the block SHALL apply the latched OP to every Q bit whose latched MASK bit is 1.
- Unmasked bits SHALL hold.
- Per-bit behaviour SHALL follow JK rules: hold / 0 / 1 / invert.
REQ-017 At the edge ending GRANT, the block SHALL also:
- clear GNT to 0;
- set PTR to (w+1) mod N_REQ;
- return the state to IDLE.
REQ-018 Latency SHALL be fixed:
- REQ sampled high in IDLE at edge k: GNT is high during cycle k+1, and the new Q is visible from edge k+2.
- Throughput SHALL be at most one operation per two cycles.
REQ-019 Requester handshake rules:
- A requester SHALL hold REQ, OP and MASK stable until it observes GNT.
- OP and MASK changes during the GRANT cycle SHALL be ignored.
- Dropping REQ before it is granted SHALL withdraw the request with no effect on Q.
REQ-020 The block SHALL ignore REQ bits during GRANT; they are re-arbitrated in the following IDLE cycle.
REQ-021 A granted operation with MASK=0 or OP=00 SHALL complete the full handshake and advance PTR, leaving Q unchanged.
REQ-022 A requester that holds REQ continuously SHALL not be granted again while any other requester has REQ=1, which guarantees no starvation.
REQ-023 With REQ all 0 in IDLE, the block SHALL hold GNT=0, BUSY=0, and Q and PTR unchanged.

Reset
REQ-024 When RST=1 at a rising edge of CP, the block SHALL set the following:
- state = IDLE;
- PTR = 0;
- GNT = 0;
- BUSY = 0;
- Q = all 0 (so QN = all 1);
- latched OP and MASK = 0.
REQ-025 RST SHALL have priority over all other activity.
- If RST=1 at the edge ending GRANT, the pending operation SHALL be discarded and Q SHALL become 0.
REQ-026 In the first cycle after RST deasserts, arbitration SHALL start from PTR=0.

Verification
REQ-027 The bench SHALL cover these directed scenarios with the defaults N_REQ=4, WIDTH=8:
- Reset check: RST=1 for 2 cycles -> Q=0x00, QN=0xFF, GNT=0000, BUSY=0.
- Single set: REQ=0001, OP0=10, MASK0=0xF0 -> GNT=0001 for one cycle, then Q=0xF0, PTR=1.
- Round-robin with four constant requesters: REQ=1111 held, OP all 11, MASK0..3 = 0x01, 0x02, 0x04, 0x08.
  - Grant order SHALL be 0,1,2,3,0.
  - GNT SHALL go high every second cycle.
  - Q after the first four grants SHALL be 0x0F.
- Toggle and clear: Q=0xF0, then r2 OP=11 MASK=0xFF -> Q=0x0F; then r3 OP=01 MASK=0x0C -> Q=0x03.
- Late change and withdrawal:
  - r1 changes MASK during GRANT -> the originally latched MASK is applied.
  - r2 drops REQ before its grant -> r2 never receives GNT, and Q is unaffected by r2.
- Reset mid-operation: RST=1 during GRANT of r0 OP=10 MASK=0xFF -> Q=0x00, GNT=0000, and the next grant goes to the lowest-index requester.

Source files
------------

// File: rtl/jk_bank_arbiter.sv
// jk_bank_arbiter: round-robin arbiter granting N_REQ requesters one at a time
// access to a shared WIDTH-bit bank of JK flip-flops. A grant lasts one cycle,
// and the winner's latched {J,K} command is applied to its masked bits at the
// edge that ends the grant.
module jk_bank_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                     i_cp,
  input  logic                     i_rst,
  input  logic [N_REQ-1:0]         i_req,
  input  logic [2*N_REQ-1:0]       i_op,
  input  logic [WIDTH*N_REQ-1:0]   i_mask,
  output logic [N_REQ-1:0]         o_gnt,
  output logic [WIDTH-1:0]         o_q,
  output logic [WIDTH-1:0]         o_qn,
  output logic                     o_busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_win;
  logic [PW-1:0]    w_win;
  logic [PW-1:0]    w_ptr_nxt;
  logic             w_found;
  logic [N_REQ-1:0] w_gnt_nxt;
  logic [1:0]       w_sel_op;
  logic [WIDTH-1:0] w_sel_mask;
  logic [N_REQ-1:0] r_gnt;
  logic [1:0]       r_op;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_q;

  // Per-bit JK update: 00 hold, 01 clear, 10 set, 11 toggle; unmasked bits hold.
  function automatic logic [WIDTH-1:0] jk_apply(input logic [WIDTH-1:0] q,
                                                input logic [1:0]       op,
                                                input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] t;
    case (op)
      2'b01:   t = '0;
      2'b10:   t = '1;
      2'b11:   t = ~q;
      default: t = q;
    endcase
    return (t & m) | (q & ~m);
  endfunction

  // Winner search: first requesting index at or above the pointer, with wrap.
  always_comb begin
    int idx;
    idx        = 0;
    w_found    = 1'b0;
    w_win      = '0;
    w_gnt_nxt  = '0;
    w_sel_op   = '0;
    w_sel_mask = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(r_ptr) + k) % N_REQ;
      if (!w_found && i_req[idx]) begin
        w_found        = 1'b1;
        w_win          = PW'(idx);
        w_gnt_nxt[idx] = 1'b1;
        w_sel_op       = i_op[2*idx +: 2];
        w_sel_mask     = i_mask[WIDTH*idx +: WIDTH];
      end
    end
  end

  // Pointer moves just past the requester that was served.
  always_comb begin
    w_ptr_nxt = '0;
    if (int'(r_win) != N_REQ - 1) begin
      w_ptr_nxt = r_win + 1'b1;
    end
  end

  // FSM state register.
  always_ff @(posedge i_cp) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next state: a grant always lasts exactly one cycle.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_nxt = S_GRANT;
      S_GRANT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // FSM outputs; QN is the only purely combinational output.
  always_comb begin
    o_busy = (r_state == S_GRANT);
    o_gnt  = r_gnt;
    o_q    = r_q;
    o_qn   = ~r_q;
  end

  // Grant, command latch, pointer and register bank updates.
  always_ff @(posedge i_cp) begin
    if (i_rst) begin
      r_gnt  <= '0;
      r_ptr  <= '0;
      r_win  <= '0;
      r_op   <= '0;
      r_mask <= '0;
      r_q    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_gnt  <= w_gnt_nxt;
            r_win  <= w_win;
            r_op   <= w_sel_op;
            r_mask <= w_sel_mask;
          end
        end
        S_GRANT: begin
          r_q   <= jk_apply(r_q, r_op, r_mask);
          r_gnt <= '0;
          r_ptr <= w_ptr_nxt;
        end
        default: r_gnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_arbiter.sv
// Directed testbench for jk_bank_arbiter with N_REQ=4, WIDTH=8.
module tb_jk_bank_arbiter;

  logic        cp;
  logic        rst;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] mask;
  logic [3:0]  gnt;
  logic [7:0]  q;
  logic [7:0]  qn;
  logic        busy;

  int checks = 0;
  int errors = 0;

  jk_bank_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .i_cp   (cp),
    .i_rst  (rst),
    .i_req  (req),
    .i_op   (op),
    .i_mask (mask),
    .o_gnt  (gnt),
    .o_q    (q),
    .o_qn   (qn),
    .o_busy (busy)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  // Advance one rising edge, then settle before driving or sampling.
  task automatic tick();
    @(posedge cp);
    #1;
  endtask

  // Issue a lone request from requester r and let it run to completion.
  task automatic run_op(input int r, input logic [1:0] o, input logic [7:0] m);
    req = '0;
    req[r] = 1'b1;
    op[2*r +: 2] = o;
    mask[8*r +: 8] = m;
    tick();
    req = '0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = '0; op = '0; mask = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp 00", q); end
    checks++; if (qn !== 8'hFF) begin errors++; $display("FAIL reset_qn got %h exp ff", qn); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
  endtask

  task automatic test_single_set();
    req = 4'b0001; op[1:0] = 2'b10; mask[7:0] = 8'hF0;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL set_gnt got %b exp 0001", gnt); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL set_busy got %b exp 1", busy); end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL set_q_early got %h exp 00", q); end
    req = '0;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL set_gnt_clr got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL set_busy_clr got %b exp 0", busy); end
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL set_q got %h exp f0", q); end
    // Pointer now 1: with r0 and r1 both asking, r1 wins. Hold op, empty mask.
    req = 4'b0011; op[3:0] = 4'b0000; mask[15:0] = 16'h0000;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL ptr1_gnt got %b exp 0010", gnt); end
    req = '0;
    tick();
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL noop_q got %h exp f0", q); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_gnt [10];
    exp_gnt = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
    do_reset();
    req = 4'b1111; op = 8'hFF; mask = 32'h08040201;
    for (int c = 0; c < 10; c++) begin
      tick();
      checks++;
      if (gnt !== exp_gnt[c]) begin
        errors++; $display("FAIL rr_gnt cycle %0d got %b exp %b", c, gnt, exp_gnt[c]);
      end
      if (c == 7) begin
        checks++; if (q !== 8'h0F) begin errors++; $display("FAIL rr_q4 got %h exp 0f", q); end
      end
    end
    checks++; if (q !== 8'h0E) begin errors++; $display("FAIL rr_q5 got %h exp 0e", q); end
    req = '0;
    tick();
  endtask

  task automatic test_toggle_clear();
    do_reset();
    op = '0; mask = '0;
    run_op(0, 2'b10, 8'hF0);
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL tc_pre got %h exp f0", q); end
    run_op(2, 2'b11, 8'hFF);
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL tc_toggle got %h exp 0f", q); end
    run_op(3, 2'b01, 8'h0C);
    checks++; if (q !== 8'h03) begin errors++; $display("FAIL tc_clear got %h exp 03", q); end
    checks++; if (qn !== 8'hFC) begin errors++; $display("FAIL tc_qn got %h exp fc", qn); end
  endtask

  task automatic test_late_change();
    // Q=03, pointer 0. r1 sets 0x30, then tries to change its command mid-grant.
    req = 4'b0010; op[3:2] = 2'b10; mask[15:8] = 8'h30;
    tick();
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL late_gnt got %b exp 0010", gnt); end
    op[3:2] = 2'b01; mask[15:8] = 8'hFF; req = '0;
    tick();
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL late_q got %h exp 33", q); end
    // Pointer 2. r3 no-op is granted; r2 asks only during that grant, then withdraws.
    req = 4'b1000; op[7:6] = 2'b00; mask[31:24] = 8'h00;
    tick();
    checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL wd_gnt3 got %b exp 1000", gnt); end
    req = 4'b0100; op[5:4] = 2'b10; mask[23:16] = 8'hC0;
    tick();
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL wd_ignored got %b exp 0000", gnt); end
    req = '0;
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (gnt !== 4'b0000 || busy !== 1'b0) begin
        errors++; $display("FAIL wd_idle cycle %0d gnt %b busy %b exp 0000 0", c, gnt, busy);
      end
    end
    checks++; if (q !== 8'h33) begin errors++; $display("FAIL wd_q got %h exp 33", q); end
  endtask

  task automatic test_reset_mid();
    // Pointer now 0 after r3. r0 set-all is interrupted by reset during grant.
    req = 4'b0001; op[1:0] = 2'b10; mask[7:0] = 8'hFF;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_gnt got %b exp 0001", gnt); end
    rst = 1'b1; req = '0;
    tick();
    rst = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL rm_q got %h exp 00", q); end
    checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rm_gnt_clr got %b exp 0000", gnt); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rm_busy got %b exp 0", busy); end
    req = 4'b1111; op = 8'h02; mask = 32'h00000081;
    tick();
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rm_next got %b exp 0001", gnt); end
    req = '0;
    tick();
    checks++; if (q !== 8'h81) begin errors++; $display("FAIL rm_q_after got %h exp 81", q); end
  endtask

  initial begin
    rst = 1'b1; req = '0; op = '0; mask = '0;
    test_reset();
    test_single_set();
    test_round_robin();
    test_toggle_clear();
    test_late_change();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
